compare_latch_seq: RTL and testbench
====================================

# compare_latch_seq

Parametrised, clocked successor to the combinational switch comparator on the DE10-Lite board. Two WIDTH-bit operands are captured one after the other from the switch bank on a load strobe. The pair is compared (unsigned or two's-complement), and the result is held on LEDs and seven-segment displays with a blinking verdict glyph. A running count of completed comparisons is also shown. The block sits between the key debouncer/strobe generator and the board I/O.

## Interface
- WIDTH, 4: operand width, legal range 1..8.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; must be ≥1.

- clk  in  1  system clock (50 MHz on board).
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  single-cycle synchronous strobe, already debounced.
- data  in  WIDTH  operand value, sampled only on load.
- signed_mode  in  1  1 = two's-complement compare; sampled with the second operand.
- leds  out  10  status LEDs, active-high.
- hex0..hex5  out  8 each  seven-segment displays, active-low, bit7 = dp (always 1).

## Operation
- States: IDLE, HAVE_A, SHOW.
  - IDLE + load → capture A, go to HAVE_A.
  - HAVE_A + load → capture B and the signed_mode bit, latch the compare result, increment count, go to SHOW.
  - SHOW + load → capture new A, clear the result, go to HAVE_A.
  - With no load, the state holds.
- Compare uses the latched mode.
  - Unsigned: plain magnitude compare.
  - Signed: the operand MSB is the sign bit.
  - WIDTH=1 in signed mode: 1 represents −1.
- Count: 4-bit, wraps 15→0, not saturating.
- leds:
  - [0] A<B
  - [1] A>B
  - [2] A==B
  - [3] HAVE_A, i.e. waiting for B
  - [4] latched signed_mode
  - [5] 0
  - [9:6] count
  - [2:0] are nonzero only in SHOW, exactly one hot.
- Hex layout:
  - hex5:hex4 = A, hex1:hex0 = B, high nibble then low nibble.
  - When WIDTH≤4 the high digit (hex5, hex1) is blank (8'hFF).
  - hex3 is always blank.
  - hex2 shows the verdict glyph: G = 8'hC2 (A>B), L = 8'hC7 (A<B), E = 8'h86 (equal).
- Display per state:
  - IDLE: all displays blank.
  - HAVE_A: A only.
  - SHOW: A, B and the glyph.
- Blink:
  - A BLINK_DIV counter runs only in SHOW.
  - Entering SHOW resets the counter to 0 and the phase to visible.
  - The phase toggles when the counter reaches BLINK_DIV−1, after which the counter returns to 0.
  - In the hidden phase hex2 = 8'hFF.
  - LEDs never blink.

## Timing
- All state is registered on the rising edge of clk. Outputs are decoded combinationally from registers only, so they are glitch-free relative to the inputs.
- Latency: a load sampled at edge k is reflected on the outputs immediately after edge k. data and signed_mode are ignored on every other cycle.
- Reset values:
  - state IDLE; A, B, count, result, blink counter all 0; phase visible.
  - leds = 10'b0; hex0..hex5 = 8'hFF.
- Reset asserted mid-operation returns everything to IDLE immediately. A load coincident with reset is discarded.
- Back-to-back loads are legal; each is honoured on its own cycle, so two consecutive strobes give A then B.
- A signed_mode change while in SHOW affects neither the result nor leds[4] until the next B capture.

## Structure
- Shared package compare_latch_pkg holds:
  - state enum (IDLE, HAVE_A, SHOW);
  - glyph constants GLYPH_G, GLYPH_L, GLYPH_E, GLYPH_BLANK.
- Sub-module: the existing sevenSeg hex-digit decoder, instantiated four times (A and B nibbles). Digits are then blanked per state/WIDTH outside the decoder.
- FSM, operand/result registers, count and blink divider live in the top module.

## Test plan
- WIDTH=4, BLINK_DIV=4:
  - After reset → leds=0, all hex=8'hFF.
  - load A=4'h9 → leds[3]=1, hex4 shows "9", hex0=8'hFF.
- WIDTH=4, unsigned: A=4'h8, B=4'h3 → leds[1]=1, hex2=8'hC2, count=1. Repeat with signed_mode=1 → leds[0]=1, hex2=8'hC7, leds[4]=1, count=2.
- WIDTH=8: A=8'h5A, B=8'h5A on consecutive cycles → leds[2]=1, hex5:hex4 and hex1:hex0 show "5A", hex2 toggles between 8'h86 and 8'hFF every 4 cycles from SHOW entry.
- Perform 17 comparisons → leds[9:6] wraps 15→0→1.
- Assert reset while in HAVE_A, with load high in the same cycle → IDLE, all outputs at reset values, count=0.
- In SHOW, toggle signed_mode with no load → leds and hex unchanged. Then load a new A → leds[2:0]=0, leds[3]=1, hex2 blank.

Source files
------------

// File: rtl/compare_latch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : compare_latch_pkg                                          |
// | Brief    : Shared state encoding and verdict glyphs for the latched   |
// |            operand comparator.                                        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package compare_latch_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t HAVE_A = 2'd1;
  localparam state_t SHOW   = 2'd2;

  // Active-low seven-segment glyphs, dp bit held high
  localparam logic [7:0] GLYPH_G     = 8'hC2;
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  // Result vector layout: [0] A<B, [1] A>B, [2] A==B
  function automatic logic [7:0] verdict_glyph(input logic [2:0] res);
    logic [7:0] g;
    g = GLYPH_BLANK;
    if (res[2])      g = GLYPH_E;
    else if (res[1]) g = GLYPH_G;
    else if (res[0]) g = GLYPH_L;
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/compare_latch_seq_sevenseg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : compare_latch_seq_sevenseg                                 |
// | Brief    : Hex nibble to active-low seven-segment decoder (the board  |
// |            sevenSeg digit decoder); dp segment always off.            |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module compare_latch_seq_sevenseg (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // Pure lookup, segment order {dp,g,f,e,d,c,b,a}
  always_comb begin
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/compare_latch_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : compare_latch_seq                                          |
// | Brief    : Captures two operands on successive load strobes, latches  |
// |            an unsigned/signed compare and shows it on LEDs and hex    |
// |            displays with a blinking verdict glyph and a pair count.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module compare_latch_seq
  import compare_latch_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             signed_mode,
  output logic [9:0]       leds,
  output logic [7:0]       hex0,
  output logic [7:0]       hex1,
  output logic [7:0]       hex2,
  output logic [7:0]       hex3,
  output logic [7:0]       hex4,
  output logic [7:0]       hex5
);

  // A BLINK_DIV of 1 still needs a one-bit counter that is always at its last value
  localparam int                   c_blink_w    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
  localparam bit                   c_hi_digit   = (WIDTH > 4);

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_mode;
  logic [2:0]           r_result;
  logic [3:0]           r_count;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_phase;

  logic                 w_lt;
  logic                 w_gt;
  logic                 w_eq;
  logic                 w_capture_b;
  logic [7:0]           w_a8;
  logic [7:0]           w_b8;
  logic [7:0]           w_seg_a_lo;
  logic [7:0]           w_seg_a_hi;
  logic [7:0]           w_seg_b_lo;
  logic [7:0]           w_seg_b_hi;

  assign w_capture_b = (r_state == HAVE_A) && load;

  // Compare stored A against the incoming B, using the mode bit that is latched alongside B
  always_comb begin
    w_lt = 1'b0;
    w_gt = 1'b0;
    if (signed_mode) begin
      w_lt = $signed(r_a) < $signed(data);
      w_gt = $signed(r_a) > $signed(data);
    end else begin
      w_lt = r_a < data;
      w_gt = r_a > data;
    end
    w_eq = (r_a == data);
  end

  // FSM with operand, mode and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_result <= 3'b000;
    end else if (load) begin
      case (r_state)
        IDLE: begin
          r_a     <= data;
          r_state <= HAVE_A;
        end
        HAVE_A: begin
          r_b      <= data;
          r_mode   <= signed_mode;
          r_result <= {w_eq, w_gt, w_lt};
          r_state  <= SHOW;
        end
        SHOW: begin
          r_a      <= data;
          r_result <= 3'b000;
          r_state  <= HAVE_A;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Completed-comparison counter, wraps naturally at 4 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (w_capture_b) begin
      r_count <= r_count + 4'd1;
    end
  end

  // Blink divider: restarts visible on SHOW entry, free-runs only while in SHOW
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if ((r_state == SHOW) && !load) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end else begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end
  end

  // Operands zero-extended to a full byte so both digits can always be decoded
  assign w_a8 = 8'(r_a);
  assign w_b8 = 8'(r_b);

  compare_latch_seq_sevenseg u_seg_a_lo (.nibble(w_a8[3:0]), .seg(w_seg_a_lo));
  compare_latch_seq_sevenseg u_seg_a_hi (.nibble(w_a8[7:4]), .seg(w_seg_a_hi));
  compare_latch_seq_sevenseg u_seg_b_lo (.nibble(w_b8[3:0]), .seg(w_seg_b_lo));
  compare_latch_seq_sevenseg u_seg_b_hi (.nibble(w_b8[7:4]), .seg(w_seg_b_hi));

  // Output decode from registers only; verdict LEDs qualified by SHOW
  always_comb begin
    leds = {r_count, 1'b0, r_mode, (r_state == HAVE_A),
            (r_state == SHOW) ? r_result : 3'b000};
    hex0 = GLYPH_BLANK;
    hex1 = GLYPH_BLANK;
    hex2 = GLYPH_BLANK;
    hex3 = GLYPH_BLANK;
    hex4 = GLYPH_BLANK;
    hex5 = GLYPH_BLANK;
    if ((r_state == HAVE_A) || (r_state == SHOW)) begin
      hex4 = w_seg_a_lo;
      hex5 = c_hi_digit ? w_seg_a_hi : GLYPH_BLANK;
    end
    if (r_state == SHOW) begin
      hex0 = w_seg_b_lo;
      hex1 = c_hi_digit ? w_seg_b_hi : GLYPH_BLANK;
      hex2 = r_phase ? GLYPH_BLANK : verdict_glyph(r_result);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compare_latch_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_compare_latch_seq                                       |
// | Brief    : Scoreboard bench for compare_latch_seq, WIDTH=4 and        |
// |            WIDTH=8 instances driven side by side.                     |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_compare_latch_seq;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] data4 = 4'h0;
  logic [7:0] data8 = 8'h00;
  logic       signed_mode = 1'b0;

  logic [9:0] leds4, leds8;
  logic [7:0] h0_4, h1_4, h2_4, h3_4, h4_4, h5_4;
  logic [7:0] h0_8, h1_8, h2_8, h3_8, h4_8, h5_8;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  compare_latch_seq #(.WIDTH(4), .BLINK_DIV(BD)) u_dut4 (
    .clk(clk), .reset(reset), .load(load), .data(data4), .signed_mode(signed_mode),
    .leds(leds4), .hex0(h0_4), .hex1(h1_4), .hex2(h2_4), .hex3(h3_4), .hex4(h4_4), .hex5(h5_4)
  );

  compare_latch_seq #(.WIDTH(8), .BLINK_DIV(BD)) u_dut8 (
    .clk(clk), .reset(reset), .load(load), .data(data8), .signed_mode(signed_mode),
    .leds(leds8), .hex0(h0_8), .hex1(h1_8), .hex2(h2_8), .hex3(h3_8), .hex4(h4_8), .hex5(h5_8)
  );

  typedef struct {
    int     st;
    int     a;
    int     b;
    bit     mode;
    bit [2:0] res;
    int     cnt;
    int     bcnt;
    bit     ph;
  } mdl_t;

  typedef struct {
    logic [9:0]  l4;
    logic [47:0] h4;
    logic [9:0]  l8;
    logic [47:0] h8;
  } exp_t;

  mdl_t m4, m8;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.st = 0; z.a = 0; z.b = 0; z.mode = 1'b0; z.res = 3'b000;
    z.cnt = 0; z.bcnt = 0; z.ph = 1'b0;
    return z;
  endfunction

  function automatic int sval(int v, bit sm, int w);
    if (sm && (((v >> (w - 1)) & 1) == 1)) return v - (1 << w);
    return v;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit ld, int d, bit sm, int w);
    mdl_t n;
    int va, vb;
    n = m;
    if (ld) begin
      case (m.st)
        0: begin n.a = d; n.st = 1; end
        1: begin
          va = sval(m.a, sm, w);
          vb = sval(d, sm, w);
          n.b = d; n.mode = sm;
          n.res = {va == vb, va > vb, va < vb};
          n.cnt = (m.cnt + 1) % 16;
          n.bcnt = 0; n.ph = 1'b0; n.st = 2;
        end
        default: begin n.a = d; n.res = 3'b000; n.st = 1; end
      endcase
    end else if (m.st == 2) begin
      if (m.bcnt == BD - 1) begin n.bcnt = 0; n.ph = !m.ph; end
      else n.bcnt = m.bcnt + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] seg7(int v);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[v & 15];
  endfunction

  function automatic logic [9:0] exp_leds(mdl_t m);
    return {4'(m.cnt), 1'b0, m.mode, (m.st == 1), (m.st == 2) ? m.res : 3'b000};
  endfunction

  function automatic logic [47:0] exp_hex(mdl_t m, int w);
    logic [47:0] r;
    r = '1;
    if (m.st != 0) begin
      r[39:32] = seg7(m.a);
      if (w > 4) r[47:40] = seg7(m.a >> 4);
    end
    if (m.st == 2) begin
      r[7:0] = seg7(m.b);
      if (w > 4) r[15:8] = seg7(m.b >> 4);
      if (!m.ph) r[23:16] = m.res[2] ? 8'h86 : m.res[1] ? 8'hC2 : m.res[0] ? 8'hC7 : 8'hFF;
    end
    return r;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.l4 = exp_leds(m4); e.h4 = exp_hex(m4, 4);
    e.l8 = exp_leds(m8); e.h8 = exp_hex(m8, 8);
    sb.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = sb.pop_front();
      check("leds4", 64'(leds4), 64'(e.l4));
      check("hex4",  64'({h5_4, h4_4, h3_4, h2_4, h1_4, h0_4}), 64'(e.h4));
      check("leds8", 64'(leds8), 64'(e.l8));
      check("hex8",  64'({h5_8, h4_8, h3_8, h2_8, h1_8, h0_8}), 64'(e.h8));
    end
  endtask

  task automatic step(input bit ld, input logic [7:0] d, input bit sm);
    @(negedge clk);
    load = ld; data4 = d[3:0]; data8 = d; signed_mode = sm;
    m4 = mdl_next(m4, ld, int'(d[3:0]), sm, 4);
    m8 = mdl_next(m8, ld, int'(d), sm, 8);
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input bit ld);
    @(negedge clk);
    reset = 1'b1; load = ld; data4 = 4'h7; data8 = 8'h77;
    m4 = mdl_zero(); m8 = mdl_zero();
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs();
    check("rst_leds4", 64'(leds4), 64'h0);
    check("rst_hex8", 64'({h5_8, h4_8, h3_8, h2_8, h1_8, h0_8}), 64'hFFFF_FFFF_FFFF);
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m4 = mdl_zero();
    m8 = mdl_zero();
    do_reset(1'b0);

    // First operand shows on hex4 only
    step(1'b1, 8'h09, 1'b0);
    check("a_led3", 64'(leds4[3]), 64'h1);
    check("a_hex4", 64'(h4_4), 64'h90);
    check("a_hex0", 64'(h0_4), 64'hFF);
    do_reset(1'b0);

    // Unsigned 8 vs 3
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    check("u_leds4", 64'(leds4), 64'h042);
    check("u_glyph4", 64'(h2_4), 64'hC2);

    // New A from SHOW clears the verdict
    step(1'b1, 8'h08, 1'b1);
    check("newa_leds4", 64'(leds4), 64'h048);
    check("newa_hex2", 64'(h2_4), 64'hFF);

    // Signed: 4-bit 8 is -8 (less), 8-bit 8 is +8 (greater)
    step(1'b1, 8'h03, 1'b1);
    check("s_leds4", 64'(leds4), 64'h091);
    check("s_glyph4", 64'(h2_4), 64'hC7);
    check("s_leds8", 64'(leds8), 64'h092);

    // Mode toggling in SHOW without load changes nothing
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b1);
    check("hold_leds4", 64'(leds4), 64'h091);
    check("hold_glyph4", 64'(h2_4), 64'hC7);

    // Back-to-back 0x5A pair, then watch the blink
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    check("eq_leds8", 64'(leds8), 64'h0C4);
    check("eq_hexa8", 64'({h5_8, h4_8}), 64'h9288);
    check("eq_hexb8", 64'({h1_8, h0_8}), 64'h9288);
    check("eq_glyph8", 64'(h2_8), 64'h86);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    check("blink_off8", 64'(h2_8), 64'hFF);
    check("blink_led8", 64'(leds8), 64'h0C4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    check("blink_on8", 64'(h2_8), 64'h86);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 60; i++)
      step(1'(($urandom % 3) == 0), 8'($urandom), 1'($urandom));

    // Seventeen comparisons wrap the 4-bit count
    do_reset(1'b0);
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 8'(k * 13), 1'($urandom));
      step(1'b1, 8'(k * 7), 1'($urandom));
      check("wrap_cnt", 64'(leds4[9:6]), 64'(k % 16));
    end

    // Reset in HAVE_A with a coincident load
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h21, 1'b0);
    do_reset(1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("post_rst_led3", 64'(leds4[3]), 64'h0);
    check("post_rst_cnt8", 64'(leds8[9:6]), 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
